pcs_stack: RTL and testbench
============================

PCS_STACK -- requirements
Module: pcs_stack

Interface
REQ-001 Parameter: WIDTH, default 16, address/data width of PC, RA and ImR.
REQ-002 Parameter: DEPTH, default 8, return-address stack entries; SHALL be a power of two, at least 2.
REQ-003 Parameter: RESET_PC, default 0, PC value loaded on reset.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: writePC  in  1  PC update enable; 0 stalls PC and stack.
REQ-007 Port: PCsrc  in  2  next-PC mode: 00 sequential, 01 ImR, 10 return (stack top), 11 relative.
REQ-008 Port: conditionalBop  in  1  taken-branch flag; redirects mode 00 to ImR.
REQ-009 Port: call  in  1  push PC_1 onto the stack, qualified by writePC.
REQ-010 Port: ret  in  1  pop the stack, qualified by writePC.
REQ-011 Port: restore  in  1  overwrite the stack top with RArestore, independent of writePC.
REQ-012 Port: RArestore  in  WIDTH  restore value.
REQ-013 Port: ImR  in  WIDTH  immediate target or offset.
REQ-014 Port: PC  out  WIDTH  registered program counter.
REQ-015 Port: PC_1  out  WIDTH  combinational PC+1, modulo 2^WIDTH.
REQ-016 Port: RA  out  WIDTH  combinational stack top; 0 when empty.
REQ-017 Port: depth  out  clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-018 Port: full, empty  out  1 each  depth==DEPTH, depth==0.
REQ-019 Port: overflow, underflow  out  1 each  sticky error flags.

Function
REQ-020 When writePC=1, PC SHALL load next-PC on the edge, visible the following cycle; when writePC=0, PC, stack, depth and flags SHALL hold, except for restore.
REQ-021 Next-PC mode 00: ImR if conditionalBop=1, else PC_1.
REQ-022 Next-PC mode 01: ImR; conditionalBop is ignored.
REQ-023 Next-PC mode 10: the RA value sampled in the same cycle, before any pop takes effect.
REQ-024 Next-PC mode 11: see REQ-036 and REQ-037.
REQ-025 All PC arithmetic SHALL wrap modulo 2^WIDTH; all-ones + 1 = 0.
REQ-026 Push (call=1, ret=0): stack top <= PC_1; depth+1.
REQ-027 Push when full: the oldest entry is overwritten (circular); depth stays DEPTH; overflow <= 1.
REQ-028 Pop (ret=1, call=0): depth-1.
REQ-029 Pop when empty: no state change except underflow <= 1; RA stays 0.
REQ-030 call=1 and ret=1 together: top replaced by PC_1 and depth unchanged; if empty, acts as a push.
REQ-031 restore=1: top <= RArestore; if empty, pushes RArestore (depth 1).
REQ-032 restore has priority: call and ret are ignored that cycle, and PC still updates per writePC.
REQ-033 overflow and underflow SHALL stay set until reset.

Reset
REQ-034 On reset=1 at an edge: PC=RESET_PC; depth=0; stack pointer=0; overflow=underflow=0. All other inputs are ignored that cycle, including mid-call or mid-return.
REQ-035 After reset: RA=0, empty=1, full=0, PC_1=RESET_PC+1; stack contents need not be cleared.

Configuration
REQ-036 Macro PCS_RELATIVE_BRANCH_EN defined: mode 11 next-PC = PC + ImR, with ImR treated as two's complement and the result wrapping.
REQ-037 Macro PCS_RELATIVE_BRANCH_EN undefined: mode 11 SHALL behave exactly as mode 00, and no relative adder is synthesised.

Verification
REQ-038 Scenario: reset, then writePC=1, PCsrc=00 for 3 cycles -> PC = 0,1,2,3; empty=1; RA=0.
REQ-039 Scenario: at PC=5, call=1, PCsrc=01, ImR=0x0040 -> next PC=0x0040, RA=0x0006, depth=1; then ret=1, PCsrc=10 -> PC=0x0006, depth=0.
REQ-040 Scenario: DEPTH=8; 9 calls from PC values 0..8 -> depth=8, full=1, overflow=1, RA=9; 8 rets return 9,8,..,2; a 9th ret sets underflow=1 and leaves PC and depth unchanged.
REQ-041 Scenario: PC=0xFFFF, PCsrc=00 -> PC=0x0000; with the macro defined, PC=0x0010, PCsrc=11, ImR=0xFFFE -> PC=0x000E; without the macro the same stimulus gives PC=0x0011.
REQ-042 Scenario: depth=2, top=0x0020; restore=1, RArestore=0x1234 with call=1 -> RA=0x1234, depth=2; then writePC=0 with call=1 -> no change.
REQ-043 Scenario: reset asserted while depth=3 and overflow=1 with call=1 -> next cycle PC=RESET_PC, depth=0, overflow=0, empty=1.

Source files
------------

// File: rtl/pcs_stack.sv
// pcs_stack -- program counter with a circular return-address stack.
//
// Optional feature: define PCS_RELATIVE_BRANCH_EN to make PCsrc=11 a
// PC-relative branch (PC + signed ImR). Undefined, mode 11 behaves as
// mode 00 and no relative adder is built.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   writePC              PC update enable (also qualifies call/ret)
//   PCsrc[1:0]           00 seq/branch, 01 ImR, 10 return (RA), 11 relative
//   conditionalBop       taken flag, redirects mode 00 to ImR
//   call, ret            push PC_1 / pop the return-address stack
//   restore, RArestore   overwrite stack top (push if empty), ignores writePC
//   ImR                  immediate target or offset
//   PC, PC_1, RA         program counter, PC+1, stack top (0 when empty)
//   depth, full, empty   stack occupancy
//   overflow, underflow  sticky error flags, cleared only by reset
module pcs_stack #(
  parameter int unsigned       WIDTH    = 16,
  parameter int unsigned       DEPTH    = 8,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     writePC,
  input  logic [1:0]               PCsrc,
  input  logic                     conditionalBop,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     restore,
  input  logic [WIDTH-1:0]         RArestore,
  input  logic [WIDTH-1:0]         ImR,
  output logic [WIDTH-1:0]         PC,
  output logic [WIDTH-1:0]         PC_1,
  output logic [WIDTH-1:0]         RA,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_IMM = 2'b01,
    PC_RET = 2'b10,
    PC_REL = 2'b11
  } pc_mode_t;

  pc_mode_t          mode;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     sp;        // next free slot; wraps so a full push hits the oldest entry
  logic [AW-1:0]     top_idx;
  logic [WIDTH-1:0]  pc_next;
  logic [WIDTH-1:0]  push_val;
  logic              do_push, do_replace, do_pop;
  logic              ovf_set, unf_set, pc_en;

  assign mode    = pc_mode_t'(PCsrc);
  assign PC_1    = PC + WIDTH'(1);
  assign top_idx = sp - AW'(1);
  assign full    = (depth == DW'(DEPTH));
  assign empty   = (depth == '0);
  assign RA      = empty ? '0 : mem[top_idx];

  // Stack operation decode; restore overrides call/ret and ignores writePC.
  always_comb begin
    do_push    = 1'b0;
    do_replace = 1'b0;
    do_pop     = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    push_val   = PC_1;
    if (restore) begin
      push_val = RArestore;
      if (empty) do_push    = 1'b1;
      else       do_replace = 1'b1;
    end else if (writePC) begin
      if (call && ret) begin
        if (empty) do_push    = 1'b1;
        else       do_replace = 1'b1;
      end else if (call) begin
        do_push = 1'b1;
        ovf_set = full;
      end else if (ret) begin
        if (empty) unf_set = 1'b1;
        else       do_pop  = 1'b1;
      end
    end
  end

  // A pop from an empty stack changes nothing but the underflow flag, PC included.
  always_comb begin
    pc_next = PC_1;
    case (mode)
      PC_IMM:  pc_next = ImR;
      PC_RET:  pc_next = RA;
`ifdef PCS_RELATIVE_BRANCH_EN
      PC_REL:  pc_next = PC + ImR;
`endif
      default: pc_next = conditionalBop ? ImR : PC_1;
    endcase
    pc_en = writePC && !unf_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC        <= RESET_PC;
      sp        <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pc_en) PC <= pc_next;
      if (do_push) begin
        sp <= sp + AW'(1);
        if (!full) depth <= depth + DW'(1);
      end else if (do_pop) begin
        sp    <= sp - AW'(1);
        depth <= depth - DW'(1);
      end
      if (ovf_set) overflow  <= 1'b1;
      if (unf_set) underflow <= 1'b1;
    end
  end

  // Stack storage is not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_push)         mem[sp]      <= push_val;
      else if (do_replace) mem[top_idx] <= push_val;
    end
  end

endmodule

// File: tb/tb_pcs_stack.sv
// tb_pcs_stack -- directed self-checking bench for pcs_stack
// (WIDTH=16, DEPTH=8, RESET_PC=0). Honours PCS_RELATIVE_BRANCH_EN.
module tb_pcs_stack;

  logic        clk = 1'b0;
  logic        reset, writePC, conditionalBop, call, ret, restore;
  logic [1:0]  PCsrc;
  logic [15:0] RArestore, ImR;
  logic [15:0] PC, PC_1, RA;
  logic [3:0]  depth;
  logic        full, empty, overflow, underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pcs_stack #(.WIDTH(16), .DEPTH(8), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .writePC(writePC), .PCsrc(PCsrc),
    .conditionalBop(conditionalBop), .call(call), .ret(ret),
    .restore(restore), .RArestore(RArestore), .ImR(ImR),
    .PC(PC), .PC_1(PC_1), .RA(RA), .depth(depth), .full(full),
    .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; writePC = 1'b1; PCsrc = 2'b00; conditionalBop = 1'b0;
    call = 1'b0; ret = 1'b0; restore = 1'b0; RArestore = '0; ImR = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    check("rst_pc",    32'(PC), 32'h0);
    check("rst_pc1",   32'(PC_1), 32'h1);
    check("rst_ra",    32'(RA), 32'h0);
    check("rst_depth", 32'(depth), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full",  32'(full), 32'h0);
    check("rst_ovf",   32'(overflow), 32'h0);
    check("rst_unf",   32'(underflow), 32'h0);

    // Sequential counting
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_pc", 32'(PC), 32'(i));
    end
    check("seq_empty", 32'(empty), 32'h1);
    check("seq_ra", 32'(RA), 32'h0);
    step(); step();
    check("seq_pc5", 32'(PC), 32'h5);

    // Call to 0x40 then return
    call = 1'b1; PCsrc = 2'b01; ImR = 16'h0040;
    step();
    check("call_pc", 32'(PC), 32'h40);
    check("call_ra", 32'(RA), 32'h6);
    check("call_depth", 32'(depth), 32'h1);
    call = 1'b0; ret = 1'b1; PCsrc = 2'b10;
    step();
    check("ret_pc", 32'(PC), 32'h6);
    check("ret_depth", 32'(depth), 32'h0);
    check("ret_empty", 32'(empty), 32'h1);

    // Branch flag: mode 00 redirected, mode 01 ignores it
    idle(); conditionalBop = 1'b1; ImR = 16'h0100;
    step();
    check("bop_taken", 32'(PC), 32'h100);
    conditionalBop = 1'b0; PCsrc = 2'b01; ImR = 16'h0200;
    step();
    check("imm_nobop", 32'(PC), 32'h200);
    idle(); writePC = 1'b0;
    step();
    check("stall_pc", 32'(PC), 32'h200);

    // Overflow / underflow
    do_reset();
    call = 1'b1;
    for (int i = 1; i <= 9; i++) step();
    check("ovf_pc", 32'(PC), 32'h9);
    check("ovf_depth", 32'(depth), 32'h8);
    check("ovf_full", 32'(full), 32'h1);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_ra", 32'(RA), 32'h9);
    call = 1'b0; ret = 1'b1; PCsrc = 2'b10;
    for (int i = 0; i < 8; i++) begin
      step();
      check("pop_pc", 32'(PC), 32'(9 - i));
    end
    check("pop_empty", 32'(empty), 32'h1);
    check("pop_unf0", 32'(underflow), 32'h0);
    step();
    check("unf_flag", 32'(underflow), 32'h1);
    check("unf_pc", 32'(PC), 32'h2);
    check("unf_depth", 32'(depth), 32'h0);
    check("unf_ra", 32'(RA), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Reset mid-call with depth 3 and overflow set
    idle(); call = 1'b1;
    step(); step(); step();
    check("pre_rst_depth", 32'(depth), 32'h3);
    reset = 1'b1;
    step();
    reset = 1'b0; call = 1'b0;
    check("midrst_pc", 32'(PC), 32'h0);
    check("midrst_depth", 32'(depth), 32'h0);
    check("midrst_ovf", 32'(overflow), 32'h0);
    check("midrst_unf", 32'(underflow), 32'h0);
    check("midrst_empty", 32'(empty), 32'h1);

    // Wrap and relative branch
    idle(); PCsrc = 2'b01; ImR = 16'hFFFF;
    step();
    check("wrap_pc", 32'(PC), 32'hFFFF);
    check("wrap_pc1", 32'(PC_1), 32'h0);
    PCsrc = 2'b00;
    step();
    check("wrap_seq", 32'(PC), 32'h0);
    PCsrc = 2'b01; ImR = 16'h0010;
    step();
    PCsrc = 2'b11; ImR = 16'hFFFE;
    step();
`ifdef PCS_RELATIVE_BRANCH_EN
    check("rel_pc", 32'(PC), 32'hE);
`else
    check("rel_pc", 32'(PC), 32'h11);
`endif

    // Restore priority, stall, call+ret replace
    do_reset();
    call = 1'b1; PCsrc = 2'b01; ImR = 16'h001F;
    step();
    PCsrc = 2'b00;
    step();
    check("rs_depth2", 32'(depth), 32'h2);
    check("rs_top", 32'(RA), 32'h20);
    restore = 1'b1; RArestore = 16'h1234;
    step();
    check("rs_ra", 32'(RA), 32'h1234);
    check("rs_depth", 32'(depth), 32'h2);
    check("rs_pc", 32'(PC), 32'h21);
    restore = 1'b0; writePC = 1'b0;
    step();
    check("stall_ra", 32'(RA), 32'h1234);
    check("stall_depth", 32'(depth), 32'h2);
    check("stall_pc2", 32'(PC), 32'h21);
    call = 1'b0; restore = 1'b1; RArestore = 16'h5555;
    step();
    check("rs_nowr_ra", 32'(RA), 32'h5555);
    check("rs_nowr_pc", 32'(PC), 32'h21);
    restore = 1'b0; writePC = 1'b1; ret = 1'b1; PCsrc = 2'b10;
    step();
    check("rs_ret_pc", 32'(PC), 32'h5555);
    check("rs_ret_ra", 32'(RA), 32'h1);
    call = 1'b1; PCsrc = 2'b00;
    step();
    check("cr_ra", 32'(RA), 32'h5556);
    check("cr_depth", 32'(depth), 32'h1);
    check("cr_pc", 32'(PC), 32'h5556);

    // Restore and call+ret on an empty stack both push
    do_reset();
    writePC = 1'b0; restore = 1'b1; RArestore = 16'hBEEF;
    step();
    check("rse_depth", 32'(depth), 32'h1);
    check("rse_ra", 32'(RA), 32'hBEEF);
    check("rse_pc", 32'(PC), 32'h0);
    do_reset();
    call = 1'b1; ret = 1'b1;
    step();
    check("cre_depth", 32'(depth), 32'h1);
    check("cre_ra", 32'(RA), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
